// File: rtl/mul64_pkg.sv
// Shared types and constants for the round-robin scheduler in front of the
// shared pipelined wide multiplier.
package mul64_pkg;

  localparam int P_WIDTH_DEF    = 64;
  localparam int PROD_WIDTH_DEF = 2 * P_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Cycles from transfer to res_valid: operand reg + multiplier stages + result reg.
  function automatic int result_latency(input int mul_lat);
    return mul_lat + 2;
  endfunction

endpackage

// File: rtl/mul64_rr_sched_if.sv
// Requester-side bundle: operand handshake in, one-hot tagged product out.
interface mul64_rr_sched_if
  import mul64_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int P_WIDTH = P_WIDTH_DEF
) ();

  logic [NUM_REQ-1:0]         in_valid;
  logic [NUM_REQ*P_WIDTH-1:0] in_a;
  logic [NUM_REQ*P_WIDTH-1:0] in_b;
  logic [NUM_REQ-1:0]         in_ready;
  logic [NUM_REQ-1:0]         res_valid;
  logic [2*P_WIDTH-1:0]       res_data;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/mul64_pipe.sv
// MUL_LAT-stage registered unsigned multiplier; the full product is formed in
// the first stage and carried through the remaining ones.
module mul64_pipe
  import mul64_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [P_WIDTH-1:0]   a,
  input  logic [P_WIDTH-1:0]   b,
  output logic [2*P_WIDTH-1:0] p
);

  logic [2*P_WIDTH-1:0] stage [MUL_LAT];

  // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/mul64_rr_sched.sv
// Round-robin arbiter, enable/flush FSM, operand register, owner tag pipe,
// in-flight counter and result register around one shared multiplier.
module mul64_rr_sched
  import mul64_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1,
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       flush,
  mul64_rr_sched_if.slave                            bus,
  output logic [$clog2(result_latency(MUL_LAT))-1:0] in_flight,
  output logic                                       busy,
  output logic                                       flush_done
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int PROD_W = 2 * P_WIDTH;

  state_t               state, state_nxt;
  logic                 grant_en;
  logic [PTR_W-1:0]     ptr, gnt_idx;
  logic [PTR_W:0]       sum;
  logic                 found;
  logic [NUM_REQ-1:0]   grant;
  logic                 transfer;
  logic [P_WIDTH-1:0]   op_a, op_b;
  logic [NUM_REQ-1:0]   tag_pipe [MUL_LAT+1];
  logic [NUM_REQ-1:0]   tag_out;
  logic                 emit;
  logic [PROD_W-1:0]    product, res_data_q;
  logic [NUM_REQ-1:0]   res_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default first so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (flush || !en) state_nxt = DRAIN;
      DRAIN:   if (in_flight == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is suppressed in exactly the cycles that leave RUN.
  always_comb begin
    busy     = (state != IDLE);
    grant_en = (state == RUN) && en && !flush;
  end

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (grant_en && !found && bus.in_valid[sum[PTR_W-1:0]]) begin
        found                  = 1'b1;
        gnt_idx                = sum[PTR_W-1:0];
        grant[sum[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

  assign transfer     = |(bus.in_valid & grant);
  assign bus.in_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: operand registers carry no reset; validity travels in the reset tag pipe.
  always_ff @(posedge clk) begin
    if (transfer) begin
      op_a <= bus.in_a[gnt_idx*P_WIDTH +: P_WIDTH];
      op_b <= bus.in_b[gnt_idx*P_WIDTH +: P_WIDTH];
    end
  end

  mul64_pipe #(
    .P_WIDTH (P_WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .a   (op_a),
    .b   (op_b),
    .p   (product)
  );

  // Tag stage 0 lines up with the operand register, stage MUL_LAT with the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MUL_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= bus.in_valid & grant;
      for (int i = 1; i <= MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[MUL_LAT];
  assign emit    = |tag_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= tag_out;
      if (emit) res_data_q <= product;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({transfer, emit})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_done <= 1'b0;
    else     flush_done <= (state == DRAIN) && (in_flight == '0);
  end

endmodule

// File: tb/tb_mul64_rr_sched.sv
// Self-checking bench: reference model predicts grants and products into a
// scoreboard; a separate monitor matches every emitted result.
module tb_mul64_rr_sched;
  import mul64_pkg::*;

  localparam int N     = 4;
  localparam int LAT_M = 1;
  localparam int P     = 64;
  localparam int LAT   = result_latency(LAT_M);
  localparam int CW    = $clog2(LAT);

  typedef enum int {M_IDLE, M_RUN, M_DRAIN} mmode_t;
  typedef struct {
    int           owner;
    logic [127:0] prod;
    int           due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, en, flush;
  logic [CW-1:0] in_flight;
  logic          busy, flush_done;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t sb[$];

  mmode_t m_mode;
  int     m_ptr;
  logic   m_fd;

  mul64_rr_sched_if #(.NUM_REQ(N), .P_WIDTH(P)) bus ();

  mul64_rr_sched #(.NUM_REQ(N), .MUL_LAT(LAT_M), .P_WIDTH(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .bus        (bus.slave),
    .in_flight  (in_flight),
    .busy       (busy),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  // Reference model: spec-level mode, rotating priority and outstanding products.
  always @(negedge clk) begin
    int           exp_if, g, j;
    logic [N-1:0] exp_gnt;
    logic [127:0] pa, pb;
    if (rst) begin
      m_mode = M_IDLE;
      m_ptr  = 0;
      m_fd   = 1'b0;
      sb.delete();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_in_flight", in_flight, 0);
      check("rst_busy", busy, 0);
      check("rst_flush_done", flush_done, 0);
    end else begin
      exp_if = 0;
      foreach (sb[k]) if (sb[k].due > cycle) exp_if++;
      check("in_flight", in_flight, exp_if);
      check("busy", busy, m_mode != M_IDLE);
      check("flush_done", flush_done, m_fd);
      exp_gnt = '0;
      g = -1;
      if (m_mode == M_RUN && en && !flush) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && bus.in_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_gnt[g] = 1'b1;
      check("in_ready", bus.in_ready, exp_gnt);
      if (g >= 0) begin
        pa = 128'(bus.in_a[g*P +: P]);
        pb = 128'(bus.in_b[g*P +: P]);
        sb.push_back('{owner: g, prod: pa * pb, due: cycle + LAT});
        m_ptr = (g + 1) % N;
      end
      m_fd = (m_mode == M_DRAIN) && (exp_if == 0);
      case (m_mode)
        M_IDLE:  if (en) m_mode = M_RUN;
        M_RUN:   if (flush || !en) m_mode = M_DRAIN;
        default: if (exp_if == 0) m_mode = M_IDLE;
      endcase
    end
  end

  // Monitor: every result must match the oldest outstanding entry, on time.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.res_valid != '0) begin
        if (sb.size() == 0) begin
          check("res_unexpected", bus.res_valid, 0);
        end else begin
          e = sb.pop_front();
          check("res_owner", bus.res_valid, 128'(1) << e.owner);
          check("res_data", bus.res_data, e.prod);
          check("res_latency", cycle, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cycle) begin
        check("res_missing", bus.res_valid, 128'(1) << sb[0].owner);
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
    bus.in_a[i*P +: P] = a;
    bus.in_b[i*P +: P] = b;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One cycle: observe grants, then retire granted requesters or refill idle ones.
  task automatic step(input logic [N-1:0] refill, input int pct);
    logic [N-1:0] g;
    @(negedge clk);
    g = bus.in_valid & bus.in_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (g[i] || !bus.in_valid[i]) begin
        if (refill[i] && $urandom_range(99) < pct) begin
          bus.in_valid[i] = 1'b1;
          set_ops(i, rand64(), rand64());
        end else begin
          bus.in_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain_inputs(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bus.in_valid == '0) return;
      step('0, 0);
    end
    if (bus.in_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: in_valid=%b still pending, required 0", bus.in_valid);
    end
  endtask

  task automatic wait_result(output logic [127:0] d, output logic [N-1:0] v);
    d = '0;
    v = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.res_valid != '0) begin
        d = bus.res_data;
        v = bus.res_valid;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL result_timeout: res_valid=0 for 20 cycles, required a result");
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [N-1:0] v;
    int           mx, fd_cnt, rv_cnt;

    rst = 1'b1; en = 1'b0; flush = 1'b0;
    bus.in_valid = '0; bus.in_a = '0; bus.in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single small product.
    en = 1'b1;
    set_ops(0, 64'd3, 64'd5);
    bus.in_valid = 4'b0001;
    drain_inputs(10);
    wait_result(d, v);
    check("t1_data", d, 128'd15);
    check("t1_owner", v, 4'b0001);
    settle();

    // Seed ptr to 0, then all four requesters contend.
    set_ops(3, rand64(), rand64());
    bus.in_valid = 4'b1000;
    @(negedge clk);
    check("rr_seed", bus.in_ready, 4'b1000);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_ops(i, rand64(), rand64());
    bus.in_valid = 4'b1111;
    mx = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_order", bus.in_ready, 4'b0001 << (k % 4));
      if (int'(in_flight) > mx) mx = int'(in_flight);
      @(posedge clk); #1;
      if (k < 4) set_ops(k % 4, rand64(), rand64());
      else       bus.in_valid[k % 4] = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      if (int'(in_flight) > mx) mx = int'(in_flight);
    end
    check("inflight_max", mx, LAT_M + 1);
    settle();

    // Largest operands.
    set_ops(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.in_valid = 4'b0100;
    drain_inputs(10);
    wait_result(d, v);
    check("max_data", d, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    check("max_owner", v, 4'b0100);
    settle();

    // Two back-to-back transfers, then flush.
    set_ops(0, rand64(), rand64());
    set_ops(1, rand64(), rand64());
    bus.in_valid = 4'b0011;
    step('0, 0);
    step('0, 0);
    flush = 1'b1;
    set_ops(2, rand64(), rand64());
    bus.in_valid = 4'b0100;
    @(negedge clk);
    check("flush_no_grant", bus.in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0; bus.in_valid = '0;
    fd_cnt = 0; rv_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (flush_done) fd_cnt++;
      if (bus.res_valid != '0) rv_cnt++;
    end
    check("flush_results", rv_cnt, 2);
    check("flush_done_cnt", fd_cnt, 1);
    check("busy_after_flush", busy, 0);
    @(posedge clk); #1;

    // Reset one cycle after a transfer discards the product.
    en = 1'b1;
    set_ops(0, rand64(), rand64());
    bus.in_valid = 4'b0001;
    drain_inputs(10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("rst_no_result", bus.res_valid, 0);
    end
    check("post_rst_in_flight", in_flight, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_flush_done", flush_done, 0);
    check("post_rst_res_data", bus.res_data, 0);
    check("post_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;

    // Pointer wrap: ptr=2 with requesters 1 and 3 pending.
    en = 1'b1;
    set_ops(1, rand64(), rand64());
    bus.in_valid = 4'b0010;
    drain_inputs(10);
    set_ops(1, rand64(), rand64());
    set_ops(3, rand64(), rand64());
    bus.in_valid = 4'b1010;
    @(negedge clk);
    check("wrap_first", bus.in_ready, 4'b1000);
    @(posedge clk); #1;
    bus.in_valid = 4'b0010;
    @(negedge clk);
    check("wrap_second", bus.in_ready, 4'b0010);
    @(posedge clk); #1;
    bus.in_valid = '0;
    settle();

    // Random traffic with occasional flush pulses and enable drops.
    for (int k = 0; k < 400; k++) begin
      step(4'b1111, 60);
      flush = ($urandom_range(99) < 3);
      if (!en) en = ($urandom_range(99) < 25);
      else     en = ($urandom_range(99) >= 3);
    end
    flush = 1'b0;
    en    = 1'b1;
    drain_inputs(60);
    settle();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul64_rr_sched.md
# mul64_rr_sched

Round-robin scheduler that shares one pipelined 64x64->128 unsigned multiplier among NUM_REQ requesters. It accepts one operand pair per cycle through a valid/ready handshake, tracks ownership of every in-flight product, and returns each 128-bit result to its originator with a one-hot valid. It sits between the FFT/NTT butterfly and twiddle-generation stages and the single shared wide multiplier. It also provides an enable/flush sequence so upstream control can drain the multiplier before reconfiguration.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MUL_LAT, 1, register stages inside the multiplier sub-module (>=1)
- P_WIDTH, 64, operand width; product width is 2*P_WIDTH
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  level enable; grants only while high
- flush  in  1  request to stop granting and drain the pipeline
- in_valid  in  NUM_REQ  per-requester operand valid
- in_a  in  NUM_REQ*P_WIDTH  operand A, requester i at bits [i*P_WIDTH +: P_WIDTH]
- in_b  in  NUM_REQ*P_WIDTH  operand B, same packing
- in_ready  out  NUM_REQ  one-hot grant, combinational
- res_valid  out  NUM_REQ  one-hot result valid, registered
- res_data  out  2*P_WIDTH  product, registered
- in_flight  out  clog2(MUL_LAT+2)  accepted but not yet returned
- busy  out  1  state != IDLE
- flush_done  out  1  one-cycle pulse when DRAIN completes

## Operation
- FSM states:
  - IDLE to RUN when en=1.
  - RUN to DRAIN when flush=1 or en=0. No grant is issued in the cycle the FSM leaves RUN.
  - DRAIN to IDLE when in_flight=0. flush_done pulses in the first IDLE cycle.
  - Leaving DRAIN takes priority over en=1.
- in_ready is nonzero only in RUN with en=1 and flush=0. At most one bit is set.
- Round-robin: the search starts at pointer ptr and wraps modulo NUM_REQ. The first i with in_valid[i]=1 gets in_ready[i].
  - After a transfer (in_valid[i] & in_ready[i]), ptr <= (i+1) mod NUM_REQ.
  - ptr holds when there is no transfer.
- Requester rule: once in_valid is raised, in_a, in_b and in_valid stay stable until the transfer. The scheduler does not check this.
- Transfer: operands are captured into the operand register. A one-hot owner tag is captured alongside and shifts through a tag pipe of depth MUL_LAT+1 matched to the datapath.
- Result path: when the tag pipe output is nonzero, res_valid <= tag and res_data <= product. Otherwise res_valid <= 0 and res_data holds.
- There is no result backpressure. Requesters sink res_valid unconditionally.
- in_flight increments on transfer and decrements on result emission. It stays unchanged when both happen in the same cycle. Maximum value is MUL_LAT+1.
- Arithmetic: unsigned full product, no truncation or modular reduction.

## Timing
- Reset values: in_ready=0, res_valid=0, res_data=0, in_flight=0, busy=0, flush_done=0, state=IDLE, ptr=0, tag pipe cleared.
- Latency: a transfer in cycle c gives res_valid in cycle c+MUL_LAT+2. That is 3 cycles at default: operand register, MUL_LAT multiplier stages, result register.
- Throughput: one transfer per cycle, back-to-back, including from the same requester.
- Results return in acceptance order.
- flush asserted in RUN with k products in flight: those k results still emerge, then flush_done follows.
- flush asserted in IDLE, or en=0 in IDLE: no effect.
- rst asserted mid-operation: everything clears immediately. In-flight products are discarded, and no res_valid or flush_done appears after rst deasserts.

## Structure
- Shared package mul64_pkg holds:
  - state encoding constants (IDLE, RUN, DRAIN),
  - P_WIDTH/product width constants,
  - the latency function MUL_LAT+2.
- One sub-module, mul64_pipe: MUL_LAT-stage registered unsigned multiplier with async active-high reset and no enable.
- The scheduler holds the arbiter, FSM, operand register, tag pipe, counter and result register.

## Test plan
- Reset, en=1, in_valid=4'b0001, a=3, b=5: in_ready[0] pulses. At c+3: res_valid=4'b0001, res_data=15. in_flight returns to 0.
- All four in_valid held for 8 cycles with distinct operands: grants are 0,1,2,3,0,1,2,3 with no bubbles, results match in the same order, and in_flight saturates at 2.
- a=b=64'hFFFF_FFFF_FFFF_FFFF: res_data=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Two back-to-back transfers, then flush=1 in the next cycle: no further grant, both results delivered, flush_done pulses once, busy=0.
- rst pulsed one cycle after a transfer: res_valid stays 0 for 10 cycles, and all outputs read their reset values.
- in_valid=4'b1010 with ptr=2: grant goes to requester 3, then requester 1.
